// File: rtl/word_splitter_pkg.sv
// -----------------------------------------------------------------------------
// word_splitter_pkg
//
// Shared definitions for the word_splitter block and its FIFO.
//   state_t        : byte-sequencer FSM encoding (IDLE, LOW, HIGH)
//   BYTE_W         : width of one byte lane presented to the 2:1 selector
//   WORD_W         : width of a buffered word (two byte lanes)
//   DEFAULT_DEPTH  : default FIFO depth in words
// -----------------------------------------------------------------------------
package word_splitter_pkg;

  localparam int BYTE_W        = 8;
  localparam int WORD_W        = 2 * BYTE_W;
  localparam int DEFAULT_DEPTH = 4;

  // LOW is always the first byte of a word and HIGH the second; which lane
  // SEL_H_L points at in each state depends on the build option.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // Split a word into its {high, low} byte lanes.
  function automatic logic [BYTE_W-1:0] low_byte(input logic [WORD_W-1:0] word);
    return word[BYTE_W-1:0];
  endfunction

  function automatic logic [BYTE_W-1:0] high_byte(input logic [WORD_W-1:0] word);
    return word[WORD_W-1:BYTE_W];
  endfunction

endpackage

// File: rtl/word_splitter_fifo.sv
// -----------------------------------------------------------------------------
// word_fifo
//
// Parameterised single-clock FIFO. Pointers wrap modulo DEPTH (power of two),
// and FULL/EMPTY are decoded from a registered occupancy count that is one bit
// wider than the pointers so that DEPTH itself is representable.
//
// Parameters
//   DEPTH  : number of entries, power of two, >= 2
//   WIDTH  : entry width in bits
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst    : synchronous active-high reset (pointers and count only)
//   push   : write wdata; ignored while full
//   wdata  : data to write
//   pop    : advance the read pointer; ignored while empty
//   rdata  : entry at the read pointer (valid while !empty)
//   count  : current occupancy
//   full   : count == DEPTH
//   empty  : count == 0
// -----------------------------------------------------------------------------
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop  && !empty;

  // Reads come straight from storage: a word written at edge N sits in mem
  // only after N, so there is no write-to-read bypass.
  assign rdata = mem[rd_ptr];

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // NOTE: storage has no reset; only pointers and count define what is valid,
  // so clearing the array would cost reset fan-out for no functional benefit.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word_splitter.sv
// -----------------------------------------------------------------------------
// word_splitter
//
// Buffers 16-bit words and feeds them, one byte per handshake, to a 2:1 byte
// selector. The popped word sits in a holding register split across ENT1
// (low byte) and ENT2 (high byte); SEL_H_L tells the selector which lane is
// current, and BYTE_VALID/BYTE_READY pace the transfer.
//
// Build option
//   WORD_SPLITTER_HIGH_FIRST_EN : when defined, each word is sent high byte
//   first (SEL_H_L = 1 then 0). ENT1/ENT2 lane assignment is unchanged.
//
// Parameters
//   DEPTH      : FIFO depth in words, power of two, >= 2
// Ports
//   CLK        : clock
//   RESET      : synchronous active-high reset; aborts any word in flight
//   WR_EN      : write strobe for WR_DATA
//   WR_DATA    : word to buffer, [7:0] low byte, [15:8] high byte
//   FULL       : FIFO holds DEPTH words (holding register not counted)
//   EMPTY      : FIFO holds no words (holding register not counted)
//   OVF        : sticky, set by a write attempt while FULL
//   ENT1       : low byte of the held word
//   ENT2       : high byte of the held word
//   SEL_H_L    : 0 selects ENT1, 1 selects ENT2
//   BYTE_VALID : selected byte is valid this cycle
//   BYTE_READY : consumer accepts the byte when BYTE_VALID & BYTE_READY
// -----------------------------------------------------------------------------
module word_splitter
  import word_splitter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_EN,
  input  logic [WORD_W-1:0] WR_DATA,
  output logic              FULL,
  output logic              EMPTY,
  output logic              OVF,
  output logic [BYTE_W-1:0] ENT1,
  output logic [BYTE_W-1:0] ENT2,
  output logic              SEL_H_L,
  output logic              BYTE_VALID,
  input  logic              BYTE_READY
);

  localparam int CW = $clog2(DEPTH) + 1;

`ifdef WORD_SPLITTER_HIGH_FIRST_EN
  localparam logic FIRST_SEL = 1'b1;
`else
  localparam logic FIRST_SEL = 1'b0;
`endif
  localparam logic SECOND_SEL = ~FIRST_SEL;

  state_t            state;
  logic [WORD_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              has_word;
  logic              pop;

  assign has_word = (fifo_count != '0);

  // A word leaves the FIFO when the holding register is free (IDLE) or when
  // the second byte of the current word is being accepted (HIGH & READY),
  // which gives back-to-back words without a bubble.
  assign pop = has_word &&
               ((state == ST_IDLE) || ((state == ST_HIGH) && BYTE_READY));

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (WR_EN),
    .wdata (WR_DATA),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign FULL  = fifo_full;
  assign EMPTY = fifo_empty;

  // Byte sequencer. Every output it drives is a register, so BYTE_READY and
  // WR_EN never reach an output combinationally.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      ENT1       <= '0;
      ENT2       <= '0;
      SEL_H_L    <= 1'b0;
      BYTE_VALID <= 1'b0;
      OVF        <= 1'b0;
    end else begin
      if (WR_EN && fifo_full) begin
        OVF <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (pop) begin
            ENT1       <= low_byte(fifo_rdata);
            ENT2       <= high_byte(fifo_rdata);
            SEL_H_L    <= FIRST_SEL;
            BYTE_VALID <= 1'b1;
            state      <= ST_LOW;
          end
        end

        // Without READY the holding register and SEL_H_L are left untouched,
        // so the presented byte stays stable under backpressure.
        ST_LOW: begin
          if (BYTE_READY) begin
            SEL_H_L <= SECOND_SEL;
            state   <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (BYTE_READY) begin
            if (pop) begin
              ENT1    <= low_byte(fifo_rdata);
              ENT2    <= high_byte(fifo_rdata);
              SEL_H_L <= FIRST_SEL;
              state   <= ST_LOW;
            end else begin
              BYTE_VALID <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end

        default: begin
          BYTE_VALID <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
